qlearn_writeback: RTL and testbench

- Stage-4 write-back for the Q-learning pipeline. Consumes the accumulated update sum from the stage-3 adder, together with its state/action tag.
- Scales and saturates the sum, writes the new Q(s,a) into the Q table, then recomputes max over actions of Q(s,·) and writes it into the Qmax table.
- Drives both tables' single-port synchronous BRAM interfaces directly; upstream is stalled via a valid/ready handshake.

---
 rtl/qlearn_writeback.sv | 135 +++++++++++++
 tb/tb_qlearn_writeback.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_writeback.sv
// Q-learning stage-4 write-back: saturates the stage-3 sum into Q(s,a), re-reads
// the action row of s and writes its maximum into the Qmax table.
module qlearn_writeback #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STATE_WIDTH  = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int NUM_ACTIONS  = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int SUM_WIDTH    = 24,
  parameter int FRAC_SHIFT   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [STATE_WIDTH-1:0]  i_state,
  input  logic [ACTION_WIDTH-1:0] i_action,
  input  logic [SUM_WIDTH-1:0]    i_sum,
  output logic [ADDR_WIDTH-1:0]   o_q_addr,
  output logic                    o_q_write,
  output logic [DATA_WIDTH-1:0]   o_q_wdata,
  input  logic [DATA_WIDTH-1:0]   i_q_rdata,
  output logic [STATE_WIDTH-1:0]  o_qmax_addr,
  output logic                    o_qmax_write,
  output logic [DATA_WIDTH-1:0]   o_qmax_wdata,
  output logic                    o_done,
  output logic [DATA_WIDTH-1:0]   o_done_qmax
);

  typedef enum logic [1:0] {IDLE, WRQ, RD, WRMAX} state_t;

  localparam logic [SUM_WIDTH-1:0]    QN_LIMIT  = SUM_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);
  localparam logic [ACTION_WIDTH-1:0] K_LAST    = ACTION_WIDTH'(NUM_ACTIONS - 1);
  localparam logic [ACTION_WIDTH:0]   NUM_ACT_W = (ACTION_WIDTH+1)'(NUM_ACTIONS);

  state_t                  state_q, state_d;
  logic [STATE_WIDTH-1:0]  s_q, s_d;
  logic [ACTION_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0]   qn_q, qn_d;
  logic [ACTION_WIDTH-1:0] k_q, k_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [DATA_WIDTH-1:0]   done_qmax_q, done_qmax_d;

  logic [SUM_WIDTH-1:0]  sum_shifted;
  logic [DATA_WIDTH-1:0] qn_sat;
  logic [DATA_WIDTH-1:0] fold_max;
  logic [ADDR_WIDTH-1:0] row_base;
  logic                  action_ok;

  always_comb begin
    sum_shifted = i_sum >> FRAC_SHIFT;
    qn_sat      = (sum_shifted > QN_LIMIT) ? {DATA_WIDTH{1'b1}} : sum_shifted[DATA_WIDTH-1:0];
    action_ok   = ({1'b0, i_action} < NUM_ACT_W);
    row_base    = ADDR_WIDTH'(s_q) * ADDR_WIDTH'(NUM_ACTIONS);
    fold_max    = (i_q_rdata > max_q) ? i_q_rdata : max_q;
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    a_d          = a_q;
    qn_d         = qn_q;
    k_d          = k_q;
    max_d        = max_q;
    done_qmax_d  = done_qmax_q;
    o_ready      = 1'b0;
    o_q_addr     = '0;
    o_q_write    = 1'b0;
    o_q_wdata    = '0;
    o_qmax_addr  = '0;
    o_qmax_write = 1'b0;
    o_qmax_wdata = '0;
    o_done       = 1'b0;
    o_done_qmax  = done_qmax_q;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          s_d  = i_state;
          a_d  = i_action;
          qn_d = qn_sat;
          // Out-of-range actions are consumed but never touch the tables.
          if (action_ok) state_d = WRQ;
        end
      end
      WRQ: begin
        o_q_write = 1'b1;
        o_q_addr  = row_base + ADDR_WIDTH'(a_q);
        o_q_wdata = qn_q;
        max_d     = '0;
        k_d       = '0;
        state_d   = RD;
      end
      RD: begin
        o_q_addr = row_base + ADDR_WIDTH'(k_q);
        k_d      = k_q + 1'b1;
        // Read data lags the address by one cycle, so the first RD cycle has nothing to fold.
        if (k_q != '0) max_d = fold_max;
        if (k_q == K_LAST) state_d = WRMAX;
      end
      WRMAX: begin
        o_qmax_write = 1'b1;
        o_qmax_addr  = s_q;
        o_qmax_wdata = fold_max;
        o_done       = 1'b1;
        o_done_qmax  = fold_max;
        done_qmax_d  = fold_max;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      a_q         <= '0;
      qn_q        <= '0;
      k_q         <= '0;
      max_q       <= '0;
      done_qmax_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      a_q         <= a_d;
      qn_q        <= qn_d;
      k_q         <= k_d;
      max_q       <= max_d;
      done_qmax_q <= done_qmax_d;
    end
  end

endmodule

// File: tb/tb_qlearn_writeback.sv
// Bench for qlearn_writeback: behavioural BRAMs, a cycle-timeline reference model
// checked every cycle, and directed updates with literal expectations.
module tb_qlearn_writeback;

  logic       clk = 1'b0;
  logic       i_rst, i_valid, o_ready;
  logic [5:0] i_state;
  logic [1:0] i_action;
  logic [23:0] i_sum;
  logic [7:0] o_q_addr, o_q_wdata, q_rdata;
  logic       o_q_write;
  logic [5:0] o_qmax_addr;
  logic       o_qmax_write;
  logic [7:0] o_qmax_wdata;
  logic       o_done;
  logic [7:0] o_done_qmax;

  always #5 clk = ~clk;

  qlearn_writeback dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_state(i_state), .i_action(i_action), .i_sum(i_sum),
    .o_q_addr(o_q_addr), .o_q_write(o_q_write), .o_q_wdata(o_q_wdata), .i_q_rdata(q_rdata),
    .o_qmax_addr(o_qmax_addr), .o_qmax_write(o_qmax_write), .o_qmax_wdata(o_qmax_wdata),
    .o_done(o_done), .o_done_qmax(o_done_qmax)
  );

  // Table memories with a bench-side preload port.
  logic [7:0] qmem [256];
  logic [7:0] qmaxmem [64];
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clk) begin
    if (pl_en) qmem[pl_addr] <= pl_data;
    else if (o_q_write) qmem[o_q_addr] <= o_q_wdata;
    q_rdata <= qmem[o_q_addr];
    if (o_qmax_write) qmaxmem[o_qmax_addr] <= o_qmax_wdata;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase = cycles since accept (0 = idle, 1 = Q write, 2..5 = row reads, 6 = Qmax write).
  logic [7:0] ref_q [256];
  int         phase = 0;
  bit         model_on = 0;
  logic [5:0] m_s = '0;
  logic [1:0] m_a = '0;
  logic [7:0] m_qn = '0;
  logic [7:0] m_last = '0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         wrq_cyc[$];

  function automatic logic [7:0] sat(input logic [23:0] sum);
    logic [23:0] t;
    t = sum >> 8;
    return (t > 24'd255) ? 8'hFF : t[7:0];
  endfunction

  function automatic logic [7:0] row_max(input logic [5:0] s);
    logic [7:0] m;
    m = 8'd0;
    for (int k = 0; k < 4; k++)
      if (ref_q[8'(s * 4 + k)] > m) m = ref_q[8'(s * 4 + k)];
    return m;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (model_on) begin
        int exp_addr;
        logic [7:0] mx;
        exp_addr = (phase == 1) ? int'(m_s) * 4 + int'(m_a) :
                   (phase >= 2 && phase <= 5) ? int'(m_s) * 4 + phase - 2 : 0;
        check("ready", int'(o_ready), int'(phase == 0));
        check("q_write", int'(o_q_write), int'(phase == 1));
        check("q_addr", int'(o_q_addr), exp_addr);
        if (phase == 1) check("q_wdata", int'(o_q_wdata), int'(m_qn));
        check("qmax_write", int'(o_qmax_write), int'(phase == 6));
        check("done", int'(o_done), int'(phase == 6));
        if (phase == 6) begin
          mx = row_max(m_s);
          check("qmax_addr", int'(o_qmax_addr), int'(m_s));
          check("qmax_wdata", int'(o_qmax_wdata), int'(mx));
          check("done_qmax", int'(o_done_qmax), int'(mx));
          m_last = mx;
        end else begin
          check("done_qmax_hold", int'(o_done_qmax), int'(m_last));
        end
      end
      if (o_done) done_cnt++;
      if (o_q_write) wrq_cyc.push_back(cyc);
      if (pl_en) ref_q[pl_addr] = pl_data;
      if (phase == 1) ref_q[8'(int'(m_s) * 4 + int'(m_a))] = m_qn;
      if (i_rst) begin
        phase = 0;
        m_last = '0;
        model_on = 1;
      end else if (phase == 0) begin
        if (i_valid) begin
          m_s = i_state;
          m_a = i_action;
          m_qn = sat(i_sum);
          phase = 1;
        end
      end else if (phase == 6) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick(1);
    pl_en = 1'b0;
  endtask

  // Presents an update and returns 1ns after the edge that accepted it; i_valid stays high.
  task automatic send(input logic [5:0] s, input logic [1:0] a, input logic [23:0] sum);
    bit acc;
    i_valid = 1'b1;
    i_state = s;
    i_action = a;
    i_sum = sum;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      acc = o_ready;
      tick(1);
      if (acc) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    tick(n);
  endtask

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_state = '0;
    i_action = '0;
    i_sum = '0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    tick(3);
    i_rst = 1'b0;

    tick(10);
    check("idle_no_writes", wrq_cyc.size(), 0);
    check("idle_ready", int'(o_ready), 1);

    for (int i = 0; i < 256; i++) load(8'(i), 8'h00);

    // Plain update into a preloaded row.
    load(8'd20, 8'd10); load(8'd21, 8'd20); load(8'd22, 8'd30); load(8'd23, 8'd40);
    send(6'd5, 2'd1, 24'h003200);
    idle(8);
    check("t1_q21", int'(qmem[21]), 'h32);
    check("t1_qmax5", int'(qmaxmem[5]), 'h32);
    check("t1_done_qmax", int'(o_done_qmax), 'h32);

    // Lowering the old argmax lowers the row maximum.
    load(8'd21, 8'd20); load(8'd23, 8'h50);
    send(6'd5, 2'd3, 24'h000500);
    idle(8);
    check("t2_q23", int'(qmem[23]), 'h05);
    check("t2_qmax5", int'(qmaxmem[5]), 'h1E);

    // Saturation.
    send(6'd7, 2'd2, 24'hFFFFFF);
    idle(8);
    check("t3_q30", int'(qmem[30]), 'hFF);
    check("t3_qmax7", int'(qmaxmem[7]), 'hFF);

    // Back-to-back with i_valid held high; second sum saturates at 0x100.
    send(6'd10, 2'd0, 24'h00AB12);
    send(6'd10, 2'd3, 24'h010000);
    idle(8);
    check("t45_gap", wrq_cyc[wrq_cyc.size()-1] - wrq_cyc[wrq_cyc.size()-2], 7);
    check("t4_q40", int'(qmem[40]), 'hAB);
    check("t5_q43", int'(qmem[43]), 'hFF);
    check("t5_qmax10", int'(qmaxmem[10]), 'hFF);
    check("t5_done_cnt", done_cnt, 5);

    // Reset during the row reads aborts the update after its Q write.
    send(6'd12, 2'd2, 24'h004400);
    i_valid = 1'b0;
    tick(2);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check("t6_ready", int'(o_ready), 1);
    idle(10);
    check("t6_q50", int'(qmem[50]), 'h44);
    check("t6_no_done", done_cnt, 5);
    check("t6_done_qmax_rst", int'(o_done_qmax), 0);

    send(6'd12, 2'd0, 24'h001100);
    idle(8);
    check("t7_q48", int'(qmem[48]), 'h11);
    check("t7_qmax12", int'(qmaxmem[12]), 'h44);
    check("t7_done_cnt", done_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
